// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_disp_pkg;

  // Scan phases: anodes off at slot start, digit driven, or nothing enabled
  typedef enum logic [1:0] {
    BLANK = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } scan_state_t;

  // Active-low segments: all ones is every segment dark (truncate to SEG_W)
  localparam logic [31:0] SEG_OFF = 32'hFFFF_FFFF;

  // Width of a counter holding 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_next_digit.sv
// Circular priority finder: first enabled digit strictly after i_sel, wrapping.
// Latency: combinational.
// Backpressure: n/a.
module seg_next_digit
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  localparam int SW = cnt_width(NUM_DIGITS)
) (
  input  logic [SW-1:0]         i_sel,
  input  logic [NUM_DIGITS-1:0] i_digit_en,
  output logic [SW-1:0]         o_next_sel,
  output logic                  o_wrap,
  output logic                  o_none
);

  logic          w_found;
  logic [SW-1:0] w_idx;

  // Walk sel+1 .. sel+NUM_DIGITS modulo NUM_DIGITS; the last probe is sel itself
  always_comb begin
    o_next_sel = i_sel;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      w_idx = SW'((int'(i_sel) + k) % NUM_DIGITS);
      if (!w_found && i_digit_en[w_idx]) begin
        o_next_sel = w_idx;
        w_found    = 1'b1;
      end
    end
  end

  assign o_none = ~|i_digit_en;
  // Landing on an index not above the current one means the frame wrapped
  assign o_wrap = !o_none && (o_next_sel <= i_sel);

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit common-anode 7-segment scanner with blank time, per-slot data latch,
// digit skip and frame strobe; optional SEG_SCAN_DIM_EN adds a 4-bit bright duty input.
// Latency: pins follow the scan state by one clk; no backpressure (free-running).
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = 7,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]                  bright,
`endif
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_tick
);

  localparam int CW = cnt_width(REFRESH_DIV);
  localparam int SW = cnt_width(NUM_DIGITS);
  localparam int BL = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
  localparam logic [SEG_W-1:0] OFF = SEG_W'(SEG_OFF);

  scan_state_t       r_state;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_sel;
  logic              r_first;
  logic [SEG_W-1:0]  r_lat_seg;
  logic              r_lat_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic [SEG_W-1:0]  r_seg;
  logic              r_dp;
  logic              r_frame;

  logic              w_slot_end;
  logic              w_blank_end;
  logic [SW-1:0]     w_next_sel;
  logic              w_wrap;
  logic              w_none;
  logic [SW-1:0]     w_lat_idx;
  logic [SEG_W-1:0]  w_seg_arr [NUM_DIGITS];
  logic [SEG_W-1:0]  w_lat_seg;
  logic              w_lat_dp;
  logic              w_duty_ok;

  seg_next_digit #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_next (
    .i_sel      (r_sel),
    .i_digit_en (digit_en),
    .o_next_sel (w_next_sel),
    .o_wrap     (w_wrap),
    .o_none     (w_none)
  );

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slice
    assign w_seg_arr[g] = seg_in[g*SEG_W +: SEG_W];
  end

  assign w_slot_end  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_blank_end = (BLANK_CYCLES == 0) || (r_cnt == CW'(BL));

  // A latch from BLANK uses the current digit; with zero blank time DRIVE is
  // re-entered straight from the slot end, so the incoming digit is latched.
  assign w_lat_idx = (r_state == BLANK) ? r_sel : w_next_sel;
  assign w_lat_seg = w_seg_arr[w_lat_idx];
  assign w_lat_dp  = ~dp_in[w_lat_idx];

`ifdef SEG_SCAN_DIM_EN
  localparam int PW = CW + 5;
  logic [3:0]    r_bright;
  logic [PW-1:0] w_on_len;
  logic [PW-1:0] w_phase;
  assign w_on_len  = (PW'(REFRESH_DIV - BLANK_CYCLES) * (PW'(r_bright) + PW'(1))) >> 4;
  assign w_phase   = PW'(r_cnt) - PW'(BLANK_CYCLES);
  assign w_duty_ok = (w_phase < w_on_len);
`else
  assign w_duty_ok = 1'b1;
`endif

  // Slot counter, scan FSM, per-slot data latch and registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sel     <= '0;
      r_state   <= BLANK;
      r_first   <= 1'b1;
      r_lat_seg <= OFF;
      r_lat_dp  <= 1'b1;
      r_an      <= '1;
      r_seg     <= OFF;
      r_dp      <= 1'b1;
      r_frame   <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      r_bright  <= 4'hF;
`endif
    end else begin
      r_cnt   <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_frame <= 1'b0;
      if (w_slot_end) r_first <= 1'b0;

      // Pins reflect the state held during the previous cycle
      if (r_state == DRIVE) begin
        r_an  <= w_duty_ok ? ~(NUM_DIGITS'(1) << r_sel) : '1;
        r_seg <= r_lat_seg;
        r_dp  <= r_lat_dp;
      end else begin
        r_an  <= '1;
        r_seg <= OFF;
        r_dp  <= 1'b1;
      end

      case (r_state)
        BLANK: begin
          if (w_blank_end) begin
            // Only the slot right after reset can start on a disabled digit 0
            if (r_first && !digit_en[r_sel]) begin
              r_state <= HOLD;
            end else begin
              r_state   <= DRIVE;
              r_lat_seg <= w_lat_seg;
              r_lat_dp  <= w_lat_dp;
`ifdef SEG_SCAN_DIM_EN
              r_bright  <= bright;
`endif
            end
          end
        end
        DRIVE, HOLD: begin
          if (w_slot_end) begin
            if (w_none) begin
              r_state <= HOLD;
            end else begin
              r_sel   <= w_next_sel;
              r_frame <= w_wrap;
              if (BLANK_CYCLES == 0) begin
                r_state   <= DRIVE;
                r_lat_seg <= w_lat_seg;
                r_lat_dp  <= w_lat_dp;
`ifdef SEG_SCAN_DIM_EN
                r_bright  <= bright;
`endif
              end else begin
                r_state <= BLANK;
              end
            end
          end
        end
        default: r_state <= BLANK;
      endcase
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame;

endmodule
